// File: rtl/hazard_stall_controller_if.sv
// ============================================================================
// Module : hazard_stall_controller_if
// Brief  : ID/EX hazard-control signal bundle between pipeline and controller
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_stall_controller_if #(
  parameter int RNW        = 4,
  parameter int STAT_WIDTH = 16
);
  logic [RNW-1:0]        RN1_ID;
  logic [RNW-1:0]        RN2_ID;
  logic                  Use1_ID;
  logic                  Use2_ID;
  logic [RNW-1:0]        RN1_EX;
  logic                  WriteReg_EX;
  logic                  MemRead_EX;
  logic                  MulDiv_EX;
  logic                  Branch_Taken_EX;
  logic                  Clear_Stats;
  logic                  PC_Write;
  logic                  IF_ID_Write;
  logic                  ID_EX_Write;
  logic                  IF_ID_Flush;
  logic                  ID_EX_Bubble;
  logic                  EX_MEM_Bubble;
  logic                  Busy;
  logic [STAT_WIDTH-1:0] Stall_Count;

  modport master (
    output RN1_ID, RN2_ID, Use1_ID, Use2_ID, RN1_EX, WriteReg_EX,
           MemRead_EX, MulDiv_EX, Branch_Taken_EX, Clear_Stats,
    input  PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Bubble,
           EX_MEM_Bubble, Busy, Stall_Count
  );

  modport slave (
    input  RN1_ID, RN2_ID, Use1_ID, Use2_ID, RN1_EX, WriteReg_EX,
           MemRead_EX, MulDiv_EX, Branch_Taken_EX, Clear_Stats,
    output PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Bubble,
           EX_MEM_Bubble, Busy, Stall_Count
  );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_controller.sv
// ============================================================================
// Module : hazard_stall_controller
// Brief  : Load-use / mul-div stall and branch-flush sequencer for ID/EX
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_controller #(
  parameter int REGISTER_NUMBER_BIT_WIDTH = 4,
  parameter int MULDIV_CYCLES             = 4,
  parameter int CNT_WIDTH                 = 3,
  parameter int STAT_WIDTH                = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  hazard_stall_controller_if.slave hz
);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_CNT_LOAD = CNT_WIDTH'(MULDIV_CYCLES - 2);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic [STAT_WIDTH-1:0] r_stall_count;

  logic w_load_use;
  logic w_pc_write;
  logic w_if_id_write;
  logic w_id_ex_write;
  logic w_if_id_flush;
  logic w_id_ex_bubble;
  logic w_ex_mem_bubble;
  logic w_busy;

  // Forwarding covers every RAW case except a load whose data is not yet back.
  assign w_load_use = hz.MemRead_EX & hz.WriteReg_EX &
                      ((hz.Use1_ID & (hz.RN1_ID == hz.RN1_EX)) |
                       (hz.Use2_ID & (hz.RN2_ID == hz.RN1_EX)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_pc_write      = 1'b1;
    w_if_id_write   = 1'b1;
    w_id_ex_write   = 1'b1;
    w_if_id_flush   = 1'b0;
    w_id_ex_bubble  = 1'b0;
    w_ex_mem_bubble = 1'b0;
    w_busy          = 1'b0;

    if (!reset_n) begin
      w_state_nxt    = ST_RUN;
      w_cnt_nxt      = '0;
      w_pc_write     = 1'b0;
      w_if_id_write  = 1'b0;
      w_id_ex_write  = 1'b0;
      w_if_id_flush  = 1'b1;
      w_id_ex_bubble = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (hz.Branch_Taken_EX) begin
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
          end else if (hz.MulDiv_EX) begin
            w_pc_write      = 1'b0;
            w_if_id_write   = 1'b0;
            w_id_ex_write   = 1'b0;
            w_ex_mem_bubble = 1'b1;
            w_cnt_nxt       = c_CNT_LOAD;
            w_state_nxt     = ST_MD_WAIT;
          end else if (w_load_use) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_bubble = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          w_busy = 1'b1;
          // cnt==0 marks the op's last EX cycle: let the pipeline advance.
          if (r_cnt != '0) begin
            w_pc_write      = 1'b0;
            w_if_id_write   = 1'b0;
            w_id_ex_write   = 1'b0;
            w_ex_mem_bubble = 1'b1;
            w_cnt_nxt       = r_cnt - 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_count <= '0;
    end else if (hz.Clear_Stats) begin
      r_stall_count <= '0;
    end else if (!w_pc_write && (r_stall_count != {STAT_WIDTH{1'b1}})) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign hz.PC_Write      = w_pc_write;
  assign hz.IF_ID_Write   = w_if_id_write;
  assign hz.ID_EX_Write   = w_id_ex_write;
  assign hz.IF_ID_Flush   = w_if_id_flush;
  assign hz.ID_EX_Bubble  = w_id_ex_bubble;
  assign hz.EX_MEM_Bubble = w_ex_mem_bubble;
  assign hz.Busy          = w_busy;
  assign hz.Stall_Count   = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
// ============================================================================
// Module : tb_hazard_stall_controller
// Brief  : Directed, model-checked bench for hazard_stall_controller
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_controller;
  localparam int c_RNW  = 4;
  localparam int c_MC   = 4;
  localparam int c_STW  = 16;
  localparam int c_SMAX = (1 << c_STW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  hazard_stall_controller_if #(.RNW(c_RNW), .STAT_WIDTH(c_STW)) hz ();

  hazard_stall_controller #(
    .REGISTER_NUMBER_BIT_WIDTH(c_RNW),
    .MULDIV_CYCLES(c_MC),
    .CNT_WIDTH(3),
    .STAT_WIDTH(c_STW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .hz(hz)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: m_pos = EX cycles the current mul/div has already spent (0 = none).
  int   m_pos = 0, n_pos = 0;
  int   m_stall = 0, n_stall = 0;
  logic e_pc, e_ifid, e_idex, e_fl, e_bub, e_exb, e_busy;
  logic lu;

  always @(negedge clk) begin
    e_pc = 1; e_ifid = 1; e_idex = 1; e_fl = 0; e_bub = 0; e_exb = 0; e_busy = 0;
    n_pos = m_pos;
    lu = hz.MemRead_EX && hz.WriteReg_EX &&
         ((hz.Use1_ID && hz.RN1_ID == hz.RN1_EX) || (hz.Use2_ID && hz.RN2_ID == hz.RN1_EX));
    if (!reset_n) begin
      e_pc = 0; e_ifid = 0; e_idex = 0; e_fl = 1; e_bub = 1; n_pos = 0;
    end else if (m_pos > 0) begin
      e_busy = 1;
      if (m_pos < c_MC - 1) begin
        e_pc = 0; e_ifid = 0; e_idex = 0; e_exb = 1; n_pos = m_pos + 1;
      end else begin
        n_pos = 0;
      end
    end else if (hz.Branch_Taken_EX) begin
      e_fl = 1; e_bub = 1;
    end else if (hz.MulDiv_EX) begin
      e_pc = 0; e_ifid = 0; e_idex = 0; e_exb = 1; n_pos = 1;
    end else if (lu) begin
      e_pc = 0; e_ifid = 0; e_bub = 1;
    end
    if (hz.Clear_Stats) n_stall = 0;
    else if (!e_pc && m_stall < c_SMAX) n_stall = m_stall + 1;
    else n_stall = m_stall;

    check("PC_Write",      hz.PC_Write,      e_pc);
    check("IF_ID_Write",   hz.IF_ID_Write,   e_ifid);
    check("ID_EX_Write",   hz.ID_EX_Write,   e_idex);
    check("IF_ID_Flush",   hz.IF_ID_Flush,   e_fl);
    check("ID_EX_Bubble",  hz.ID_EX_Bubble,  e_bub);
    check("EX_MEM_Bubble", hz.EX_MEM_Bubble, e_exb);
    check("Busy",          hz.Busy,          e_busy);
    check("Stall_Count",   32'(hz.Stall_Count), 32'(m_stall));
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pos = 0; m_stall = 0;
    end else begin
      m_pos = n_pos; m_stall = n_stall;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hz.RN1_ID = '0; hz.RN2_ID = '0; hz.Use1_ID = 0; hz.Use2_ID = 0;
    hz.RN1_EX = '0; hz.WriteReg_EX = 0; hz.MemRead_EX = 0;
    hz.MulDiv_EX = 0; hz.Branch_Taken_EX = 0; hz.Clear_Stats = 0;
  endtask

  task automatic set_load_use();
    hz.MemRead_EX = 1; hz.WriteReg_EX = 1; hz.RN1_EX = 4'd3;
    hz.RN2_ID = 4'd3; hz.Use2_ID = 1;
  endtask

  initial begin
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 reset_n = 1;

    // Reset release, no events
    @(negedge clk);
    check("t1_pc", hz.PC_Write, 1'b1);
    check("t1_ifid", hz.IF_ID_Write, 1'b1);
    check("t1_flush", hz.IF_ID_Flush, 1'b0);
    check("t1_cnt", 32'(hz.Stall_Count), 32'd0);

    // Single-cycle load-use stall
    step(); set_load_use();
    @(negedge clk);
    check("t2_pc", hz.PC_Write, 1'b0);
    check("t2_bub", hz.ID_EX_Bubble, 1'b1);
    step(); idle_inputs();
    @(negedge clk);
    check("t2_pc_after", hz.PC_Write, 1'b1);
    check("t2_cnt", 32'(hz.Stall_Count), 32'd1);

    // Unused operand match, then branch overriding a load-use
    step(); set_load_use(); hz.Use2_ID = 0; hz.Use1_ID = 1; hz.RN1_ID = 4'd5;
    @(negedge clk);
    check("t3_nostall", hz.PC_Write, 1'b1);
    step(); hz.Use2_ID = 1; hz.Branch_Taken_EX = 1;
    @(negedge clk);
    check("t3_flush", hz.IF_ID_Flush, 1'b1);
    check("t3_bub", hz.ID_EX_Bubble, 1'b1);
    check("t3_pc", hz.PC_Write, 1'b1);
    step(); idle_inputs();

    // Mul/div, then a back-to-back second op
    hz.Clear_Stats = 1;
    step(); hz.Clear_Stats = 0; hz.MulDiv_EX = 1;
    begin
      int s;
      s = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (!hz.PC_Write) s++;
      end
      check("t4_stall_cycles", 32'(s), 32'd3);
    end
    @(negedge clk);
    check("t4_cnt1", 32'(hz.Stall_Count), 32'd3);
    check("t4_b2b_run", hz.Busy, 1'b0);
    check("t4_b2b_stall", hz.PC_Write, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 hz.MulDiv_EX = 0;
    @(negedge clk);
    check("t4_cnt2", 32'(hz.Stall_Count), 32'd6);
    check("t4_done", hz.PC_Write, 1'b1);

    // Async reset in the middle of a mul/div wait
    step(); hz.Clear_Stats = 1;
    step(); hz.Clear_Stats = 0; hz.MulDiv_EX = 1;
    step(); step();
    #1 reset_n = 0;
    #1;
    check("t5_busy", hz.Busy, 1'b0);
    check("t5_cnt", 32'(hz.Stall_Count), 32'd0);
    check("t5_pc", hz.PC_Write, 1'b0);
    check("t5_flush", hz.IF_ID_Flush, 1'b1);
    #1 reset_n = 1; hz.MulDiv_EX = 0;
    @(negedge clk);
    check("t5_run_busy", hz.Busy, 1'b0);
    check("t5_run_pc", hz.PC_Write, 1'b1);

    // Saturation, then clear while stalling
    step(); hz.Clear_Stats = 1;
    step(); hz.Clear_Stats = 0; set_load_use();
    repeat ((1 << c_STW) + 5) @(posedge clk);
    @(negedge clk);
    check("t6_sat", 32'(hz.Stall_Count), 32'hFFFF);
    step(); hz.Clear_Stats = 1;
    step(); hz.Clear_Stats = 0;
    @(negedge clk);
    check("t6_clear", 32'(hz.Stall_Count), 32'd0);
    step(); idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
